// File: rtl/alarm_clock_pkg.sv
// Shared mode encoding and BCD digit limits for the alarm-clock controller.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    ModeRun      = 2'b00,
    ModeSetTime  = 2'b01,
    ModeSetAlarm = 2'b10
  } mode_e;

  localparam logic [3:0] HourTensMax  = 4'd2;
  localparam logic [3:0] HourUnitsMax = 4'd3;
  localparam logic [3:0] MinTensMax   = 4'd5;
  localparam logic [3:0] MinUnitsMax  = 4'd9;

endpackage

// File: rtl/bcd_hhmm_inc.sv
// Combinational BCD HH:MM incrementer; minute rollover carries into the hour only when carry_en.
module bcd_hhmm_inc
  import alarm_clock_pkg::*;
(
  input  logic [15:0] time_in,
  input  logic        inc_min,
  input  logic        inc_hour,
  input  logic        carry_en,
  output logic [15:0] time_out
);

  logic [3:0] hour_tens, hour_units, min_tens, min_units;
  logic       min_wrap;
  logic       hour_step;

  always_comb begin
    {hour_tens, hour_units, min_tens, min_units} = time_in;
    min_wrap  = (min_tens == MinTensMax) && (min_units == MinUnitsMax);
    hour_step = inc_hour | (inc_min & carry_en & min_wrap);

    if (inc_min) begin
      if (min_units == MinUnitsMax) begin
        min_units = 4'd0;
        min_tens  = (min_tens == MinTensMax) ? 4'd0 : min_tens + 4'd1;
      end else begin
        min_units = min_units + 4'd1;
      end
    end

    if (hour_step) begin
      if ((hour_tens == HourTensMax) && (hour_units == HourUnitsMax)) begin
        hour_tens  = 4'd0;
        hour_units = 4'd0;
      end else if (hour_units == 4'd9) begin
        hour_units = 4'd0;
        hour_tens  = hour_tens + 4'd1;
      end else begin
        hour_units = hour_units + 4'd1;
      end
    end

    time_out = {hour_tens, hour_units, min_tens, min_units};
  end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm-clock mode FSM, minute prescaler and time/alarm registers.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on hour_btn/min_btn.
module alarm_clock_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int unsigned  TICKS_PER_MIN = 6000,
  parameter logic [15:0]  RESET_TIME    = 16'h1200,
  parameter logic [15:0]  RESET_ALARM   = 16'h0600,
  parameter int unsigned  REPEAT_DELAY  = 500,
  parameter int unsigned  REPEAT_PERIOD = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_time_btn,
  input  logic        set_alarm_btn,
  input  logic        hour_btn,
  input  logic        min_btn,
  output logic [15:0] current_time,
  output logic [15:0] alarm_time,
  output logic        show_alarm,
  output logic        one_minute,
  output logic [1:0]  mode
);

  localparam int unsigned PreW = $clog2(TICKS_PER_MIN);
  localparam logic [PreW-1:0] PreLast = PreW'(TICKS_PER_MIN - 1);

  if (TICKS_PER_MIN < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_param
    $error("alarm_clock_ctrl: TICKS_PER_MIN must be >= 2 and repeat timings non-zero");
  end

  mode_e            mode_q, mode_d;
  logic [PreW-1:0]  prescaler_q, prescaler_d;
  logic [15:0]      current_time_q, current_time_d;
  logic [15:0]      alarm_time_q, alarm_time_d;
  logic             show_alarm_q, one_minute_q;
  logic [3:0]       btn, btn_q, btn_ev;
  logic [1:0]       rpt_ev, fld_ev;
  logic             tick;
  logic             in_set_time, in_set_alarm;

  // Bit order: {set_time, set_alarm, hour, min}
  assign btn    = {set_time_btn, set_alarm_btn, hour_btn, min_btn};
  assign btn_ev = btn & ~btn_q;
  assign fld_ev = btn_ev[1:0] | rpt_ev;

  assign in_set_time  = (mode_q == ModeSetTime);
  assign in_set_alarm = (mode_q == ModeSetAlarm);

  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      ModeRun: begin
        if (btn_ev[3])      mode_d = ModeSetTime;
        else if (btn_ev[2]) mode_d = ModeSetAlarm;
      end
      ModeSetTime:  if (btn_ev[3]) mode_d = ModeRun;
      ModeSetAlarm: if (btn_ev[2]) mode_d = ModeRun;
      default:      mode_d = ModeRun;
    endcase
  end

  // Holding at 0 on entry and exit guarantees a full minute after leaving SET_TIME.
  assign tick = !in_set_time && (prescaler_q == PreLast);

  always_comb begin
    prescaler_d = prescaler_q + PreW'(1);
    if (in_set_time || (mode_d == ModeSetTime) || tick) prescaler_d = '0;
  end

  bcd_hhmm_inc u_time_inc (
    .time_in  (current_time_q),
    .inc_min  (in_set_time ? fld_ev[0] : tick),
    .inc_hour (in_set_time & fld_ev[1]),
    .carry_en (!in_set_time),
    .time_out (current_time_d)
  );

  bcd_hhmm_inc u_alarm_inc (
    .time_in  (alarm_time_q),
    .inc_min  (in_set_alarm & fld_ev[0]),
    .inc_hour (in_set_alarm & fld_ev[1]),
    .carry_en (1'b0),
    .time_out (alarm_time_d)
  );

`ifdef AUTO_REPEAT_EN
  logic [1:0][31:0] rpt_cnt_q, rpt_cnt_d;
  logic [1:0]       rpt_phase_q, rpt_phase_d;

  // rpt_cnt counts cycles since the last event; phase selects delay vs. period.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_ev      = '0;
    for (int i = 0; i < 2; i++) begin
      if (!btn[i] || (mode_d != mode_q)) begin
        rpt_cnt_d[i]   = '0;
        rpt_phase_d[i] = 1'b0;
      end else if (btn_ev[i]) begin
        rpt_cnt_d[i]   = 32'd1;
        rpt_phase_d[i] = 1'b0;
      end else if (rpt_cnt_q[i] != '0 &&
                   rpt_cnt_q[i] == (rpt_phase_q[i] ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY))) begin
        rpt_ev[i]      = 1'b1;
        rpt_cnt_d[i]   = 32'd1;
        rpt_phase_d[i] = 1'b1;
      end else if (rpt_cnt_q[i] != '0) begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= '0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  assign rpt_ev = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q         <= ModeRun;
      prescaler_q    <= '0;
      current_time_q <= RESET_TIME;
      alarm_time_q   <= RESET_ALARM;
      show_alarm_q   <= 1'b0;
      one_minute_q   <= 1'b0;
      btn_q          <= '0;
    end else begin
      mode_q         <= mode_d;
      prescaler_q    <= prescaler_d;
      current_time_q <= current_time_d;
      alarm_time_q   <= alarm_time_d;
      show_alarm_q   <= (mode_d == ModeSetAlarm);
      one_minute_q   <= tick;
      btn_q          <= btn;
    end
  end

  assign current_time = current_time_q;
  assign alarm_time   = alarm_time_q;
  assign show_alarm   = show_alarm_q;
  assign one_minute   = one_minute_q;
  assign mode         = mode_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed self-checking bench for alarm_clock_ctrl with TICKS_PER_MIN=4.
module tb_alarm_clock_ctrl;

  localparam logic [3:0] BST = 4'b1000;
  localparam logic [3:0] BSA = 4'b0100;
  localparam logic [3:0] BHR = 4'b0010;
  localparam logic [3:0] BMN = 4'b0001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        set_time_btn = 1'b0, set_alarm_btn = 1'b0, hour_btn = 1'b0, min_btn = 1'b0;
  logic [15:0] current_time, alarm_time;
  logic        show_alarm, one_minute;
  logic [1:0]  mode;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alarm_clock_ctrl #(
    .TICKS_PER_MIN (4),
    .RESET_TIME    (16'h1200),
    .RESET_ALARM   (16'h0600),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .set_time_btn  (set_time_btn),
    .set_alarm_btn (set_alarm_btn),
    .hour_btn      (hour_btn),
    .min_btn       (min_btn),
    .current_time  (current_time),
    .alarm_time    (alarm_time),
    .show_alarm    (show_alarm),
    .one_minute    (one_minute),
    .mode          (mode)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    {set_time_btn, set_alarm_btn, hour_btn, min_btn} = m;
    step(1);
    {set_time_btn, set_alarm_btn, hour_btn, min_btn} = 4'b0000;
    step(1);
  endtask

  task automatic press_n(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    {set_time_btn, set_alarm_btn, hour_btn, min_btn} = 4'b0000;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(3);
    checks++; if (current_time !== 16'h1200) begin failures++;
      $display("FAIL reset_ct: got %h want 1200", current_time); end
    checks++; if (alarm_time !== 16'h0600) begin failures++;
      $display("FAIL reset_at: got %h want 0600", alarm_time); end
    checks++; if (mode !== 2'b00) begin failures++;
      $display("FAIL reset_mode: got %b want 00", mode); end
    checks++; if (show_alarm !== 1'b0 || one_minute !== 1'b0) begin failures++;
      $display("FAIL reset_flags: got show=%b om=%b want 0 0", show_alarm, one_minute); end
    reset = 1'b1;
    step(3);
    checks++; if (current_time !== 16'h1200 || one_minute !== 1'b0) begin failures++;
      $display("FAIL pre_tick: got %h om=%b want 1200 om=0", current_time, one_minute); end
    step(1);
    checks++; if (current_time !== 16'h1201 || one_minute !== 1'b1) begin failures++;
      $display("FAIL first_tick: got %h om=%b want 1201 om=1", current_time, one_minute); end
    step(1);
    checks++; if (one_minute !== 1'b0 || current_time !== 16'h1201) begin failures++;
      $display("FAIL om_width: got %h om=%b want 1201 om=0", current_time, one_minute); end
  endtask

  task automatic test_tick_rollover();
    do_reset();
    press(BST);
    checks++; if (mode !== 2'b01) begin failures++;
      $display("FAIL enter_set_time: got %b want 01", mode); end
    press_n(BHR, 11);
    press_n(BMN, 59);
    checks++; if (current_time !== 16'h2359) begin failures++;
      $display("FAIL preload_2359: got %h want 2359", current_time); end
    press(BST);
    checks++; if (mode !== 2'b00) begin failures++;
      $display("FAIL exit_set_time: got %b want 00", mode); end
    step(2);
    checks++; if (current_time !== 16'h2359 || one_minute !== 1'b0) begin failures++;
      $display("FAIL full_minute_after_exit: got %h om=%b want 2359 om=0",
               current_time, one_minute); end
    step(1);
    checks++; if (current_time !== 16'h0000 || one_minute !== 1'b1) begin failures++;
      $display("FAIL rollover_0000: got %h om=%b want 0000 om=1", current_time, one_minute); end

    do_reset();
    press(BST);
    press_n(BHR, 21);
    press_n(BMN, 59);
    checks++; if (current_time !== 16'h0959) begin failures++;
      $display("FAIL preload_0959: got %h want 0959", current_time); end
    press(BST);
    step(3);
    checks++; if (current_time !== 16'h1000) begin failures++;
      $display("FAIL carry_1000: got %h want 1000", current_time); end
  endtask

  task automatic test_set_fields();
    int pulses;
    do_reset();
    press(BST);
    press_n(BMN, 59);
    checks++; if (current_time !== 16'h1259) begin failures++;
      $display("FAIL set_1259: got %h want 1259", current_time); end
    press(BMN);
    checks++; if (current_time !== 16'h1200) begin failures++;
      $display("FAIL min_no_carry: got %h want 1200", current_time); end
    press_n(BHR, 11);
    checks++; if (current_time !== 16'h2300) begin failures++;
      $display("FAIL set_2300: got %h want 2300", current_time); end
    press(BHR);
    checks++; if (current_time !== 16'h0000) begin failures++;
      $display("FAIL hour_wrap: got %h want 0000", current_time); end
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (one_minute === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || current_time !== 16'h0000) begin failures++;
      $display("FAIL no_tick_in_set: got pulses=%0d ct=%h want 0 0000", pulses, current_time); end
    press(BST);
  endtask

  task automatic test_set_alarm();
    do_reset();
    press(BSA);
    checks++; if (mode !== 2'b10 || show_alarm !== 1'b1) begin failures++;
      $display("FAIL enter_alarm: got mode=%b show=%b want 10 1", mode, show_alarm); end
    press_n(BHR, 3);
    checks++; if (alarm_time !== 16'h0900) begin failures++;
      $display("FAIL alarm_0900: got %h want 0900", alarm_time); end
    checks++; if (current_time !== 16'h1202) begin failures++;
      $display("FAIL ticks_in_alarm: got %h want 1202", current_time); end
    press(BST);
    checks++; if (mode !== 2'b10) begin failures++;
      $display("FAIL ignore_set_time: got %b want 10", mode); end
    press(BSA);
    checks++; if (mode !== 2'b00 || show_alarm !== 1'b0) begin failures++;
      $display("FAIL exit_alarm: got mode=%b show=%b want 00 0", mode, show_alarm); end
    checks++; if (current_time !== 16'h1203 || alarm_time !== 16'h0900) begin failures++;
      $display("FAIL after_alarm: got ct=%h at=%h want 1203 0900", current_time, alarm_time); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    press(BST | BSA);
    checks++; if (mode !== 2'b01 || show_alarm !== 1'b0) begin failures++;
      $display("FAIL both_mode_btns: got mode=%b show=%b want 01 0", mode, show_alarm); end
    press(BHR | BMN);
    checks++; if (current_time !== 16'h1301) begin failures++;
      $display("FAIL both_fields: got %h want 1301", current_time); end
    press(BST | BMN);
    checks++; if (mode !== 2'b00 || current_time !== 16'h1302) begin failures++;
      $display("FAIL exit_with_field: got mode=%b ct=%h want 00 1302", mode, current_time); end
    step(3);
    checks++; if (current_time !== 16'h1303) begin failures++;
      $display("FAIL tick_after_exit: got %h want 1303", current_time); end
  endtask

  task automatic test_async_reset();
    do_reset();
    press(BSA);
    press_n(BHR, 2);
    checks++; if (alarm_time !== 16'h0800 || current_time !== 16'h1201) begin failures++;
      $display("FAIL pre_async: got at=%h ct=%h want 0800 1201", alarm_time, current_time); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (alarm_time !== 16'h0600 || mode !== 2'b00 || show_alarm !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got at=%h mode=%b show=%b want 0600 00 0",
               alarm_time, mode, show_alarm); end
    checks++; if (current_time !== 16'h1200) begin failures++;
      $display("FAIL async_reset_ct: got %h want 1200", current_time); end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_auto_repeat();
    logic [15:0] want;
`ifdef AUTO_REPEAT_EN
    want = 16'h1205;
`else
    want = 16'h1201;
`endif
    do_reset();
    press(BST);
    min_btn = 1'b1;
    step(30);
    min_btn = 1'b0;
    step(1);
    checks++; if (current_time !== want) begin failures++;
      $display("FAIL hold_min: got %h want %h", current_time, want); end
    step(20);
    checks++; if (current_time !== want) begin failures++;
      $display("FAIL no_repeat_after_release: got %h want %h", current_time, want); end
    press(BST);
  endtask

  initial begin
    test_reset();
    test_tick_rollover();
    test_set_fields();
    test_set_alarm();
    test_back_to_back();
    test_async_reset();
    test_auto_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_clock_ctrl.md
# alarm_clock_ctrl

Mode controller and timekeeper for the alarm-clock datapath. Owns the current-time and alarm-time BCD registers (HH:MM, 16 bits, one nibble per digit) and generates the one-minute tick. Sequences user time/alarm setting from four debounced buttons. Feeds the display/alarm driver through its `current_time`, `alarm_time` and `show_alarm` inputs.

## Interface
- `TICKS_PER_MIN`, default 6000, is the number of `clk` cycles per minute. It must be at least 2.
- `RESET_TIME`, default 16'h1200, is the BCD value loaded into `current_time` at reset.
- `RESET_ALARM`, default 16'h0600, is the BCD value loaded into `alarm_time` at reset.
- `REPEAT_DELAY`, default 500, is the number of cycles a button must be held before auto-repeat starts. It is used only with `AUTO_REPEAT_EN`.
- `REPEAT_PERIOD`, default 100, is the number of cycles between auto-repeat steps. It is used only with `AUTO_REPEAT_EN`.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low reset (the block is in reset while `reset`=0).
- `set_time_btn`  in  1  level, synchronous and debounced; toggles SET_TIME mode.
- `set_alarm_btn`  in  1  level; toggles SET_ALARM mode.
- `hour_btn`  in  1  level; increments the hour field of the selected register.
- `min_btn`  in  1  level; increments the minute field of the selected register.
- `current_time`  out  16  BCD HHMM, registered.
- `alarm_time`  out  16  BCD HHMM, registered.
- `show_alarm`  out  1  high while in SET_ALARM, registered.
- `one_minute`  out  1  one-cycle pulse each minute rollover, registered.
- `mode`  out  2  00 RUN, 01 SET_TIME, 10 SET_ALARM.

## Operation
- Reset (asynchronous, on `reset`=0) sets the following values:
  - `current_time`=RESET_TIME, `alarm_time`=RESET_ALARM.
  - `mode`=RUN; `show_alarm`=0; `one_minute`=0.
  - prescaler=0; all button-history registers=0.
- Each button is edge-detected against a registered copy. An "event" is input=1 while its copy=0.
- FSM transitions:
  - RUN →SET_TIME on a `set_time_btn` event; RUN →SET_ALARM on a `set_alarm_btn` event.
  - SET_TIME →RUN on a `set_time_btn` event; SET_ALARM →RUN on a `set_alarm_btn` event.
  - In a SET state, an event on the other mode button is ignored.
  - Simultaneous `set_time_btn` and `set_alarm_btn` events in RUN: `set_time_btn` wins.
- RUN behaviour:
  - Prescaler counts 0..TICKS_PER_MIN-1 and wraps.
  - On the wrap edge, `current_time` increments by one minute and `one_minute` pulses.
  - `hour_btn` and `min_btn` are ignored.
- SET_TIME behaviour:
  - Prescaler is held at 0, so no ticks occur.
  - A `hour_btn` event increments the hour of `current_time`; a `min_btn` event increments the minute.
  - On exit to RUN, the prescaler restarts from 0, so a full minute elapses before the next tick.
- SET_ALARM behaviour:
  - The prescaler keeps running and ticks continue normally.
  - `hour_btn` and `min_btn` edit `alarm_time` instead.
- BCD arithmetic rules:
  - Tick increment: 59 min carries into the hour; 23:59 →00:00.
  - Setting increments are per field with no carry. Minutes go 59→00 with the hour unchanged; hours go 23→00 with the minute unchanged.
  - Each digit is always in range: HH 00..23, MM 00..59.
- Simultaneous `hour_btn` and `min_btn` events apply both fields in the same cycle.

## Timing
- Button event to updated register or `mode`: 1 cycle. The value is visible after the edge that samples the event.
- Tick: at the edge where prescaler=TICKS_PER_MIN-1, the following update together:
  - `current_time` updates;
  - `one_minute` goes high for exactly the next cycle.
- Events at the same edge:
  - A tick coinciding with a RUN →SET_TIME transition is applied.
  - A mode-exit event and a field event in the same cycle: the field increment is still applied.
- When `reset` is asserted mid-operation, all outputs take their reset values immediately and asynchronously.

## Configuration
- `AUTO_REPEAT_EN` defined: a `hour_btn` or `min_btn` held continuously repeats its event.
  - The first repeat is REPEAT_DELAY cycles after the initial event, then one every REPEAT_PERIOD cycles.
  - Each button has its own counter. The counter clears on release or on a mode change.
- `AUTO_REPEAT_EN` undefined: the repeat counters are removed and only edges produce events.
- The parameters REPEAT_DELAY and REPEAT_PERIOD stay in the interface either way but are unused without the macro.

## Structure
- Package `alarm_clock_pkg` holds:
  - the mode encoding constants (RUN, SET_TIME, SET_ALARM);
  - BCD limit constants 4'd2/4'd3 (hour tens and units at max) and 4'd5/4'd9 (minute tens and units at max).
- Sub-module `bcd_hhmm_inc` is purely combinational:
  - inputs: 16-bit time, `inc_min`, `inc_hour`, `carry_en`;
  - output: next 16-bit time.
- The block uses one `bcd_hhmm_inc` instance per register (two in total).

## Test plan
- Reset with defaults, TICKS_PER_MIN=4: `current_time`=1200 and `alarm_time`=0600; after 4 cycles `current_time`=1201 and `one_minute` pulses once.
- Preload to 23:59 via SET_TIME (hour ×11 from 12, min ×59), return to RUN, wait one minute → `current_time`=0000; 09:59 → 10:00.
- SET_TIME at 12:59, one `min_btn` event → 12:00 (no hour carry); hour from 23 → 00. No `one_minute` pulse for 20×TICKS cycles while in SET_TIME.
- SET_ALARM: `show_alarm`=1 and `mode`=10. `hour_btn` ×3 → `alarm_time`=0900 while `current_time` keeps ticking. A `set_time_btn` press is ignored; a `set_alarm_btn` press → RUN with `show_alarm`=0.
- `set_time_btn` and `set_alarm_btn` rising on the same cycle in RUN → `mode`=01. Simultaneous `hour_btn` and `min_btn` events from 12:00 → 13:01.
- Reset asserted mid SET_ALARM after edits → `alarm_time`=0600 and `mode`=00 asynchronously. With `AUTO_REPEAT_EN`, REPEAT_DELAY=10 and REPEAT_PERIOD=5, hold `min_btn` 30 cycles from :00 → :05 (1 event + 4 repeats).
